uart_receiver: RTL and testbench

Serial-to-parallel UART receive stage: 8 data bits, no parity, 1 stop bit, LSB first. It sits directly downstream of the transmit stage and consumes its `tx_out` line, either looped back for self-test or across the board link. It recovers bytes using the same bit-period parameter, samples each bit at mid-period, and presents each byte with a one-cycle valid strobe plus framing-error reporting.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_receiver_if.sv | 27 ++
 rtl/uart_rx_sync.sv | 31 +++
 rtl/uart_receiver.sv | 132 +++++++++++++
 tb/tb_uart_receiver.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings common to the transmit and receive
// stages, frame width and the default bit-period terminal count.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_e;

    localparam int unsigned DATA_BITS      = 8;
    localparam int unsigned MAX_BAUD_COUNT = 10417;
    localparam int unsigned BAUD_CNT_W     = 15;

endpackage

// File: rtl/uart_receiver_if.sv
// Receive-side bundle: serial line in, recovered byte with status strobes out.
interface uart_receiver_if;
    import uart_pkg::*;

    logic                 rx_in;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 framing_error;
    logic                 busy;

    modport master (
        input  rx_in,
        output data_out,
        output data_valid,
        output framing_error,
        output busy
    );

    modport slave (
        output rx_in,
        input  data_out,
        input  data_valid,
        input  framing_error,
        input  busy
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus a falling-edge
// detector; all stages reset to the idle (high) line level.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx_in,
    output logic rx_s,
    output logic fall
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;

    // Metastability chain followed by the previous-value stage for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b1;
        end else begin
            sync1_r <= rx_in;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    assign rx_s = sync2_r;
    assign fall = prev_r & ~sync2_r;

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage (8N1, LSB first): mid-bit sampling driven by a per-bit
// counter, registered byte output with one-cycle valid / framing-error strobes.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned max_baud_count = MAX_BAUD_COUNT
) (
    input  logic            clk,
    input  logic            reset,
    uart_receiver_if.master rx_bus
);

    localparam logic [BAUD_CNT_W-1:0] BAUD_MAX  = BAUD_CNT_W'(max_baud_count);
    localparam logic [BAUD_CNT_W-1:0] BAUD_HALF = BAUD_CNT_W'(max_baud_count / 2);

    logic rx_s;
    logic fall_s;

    uart_state_e           state_r, state_s;
    logic [BAUD_CNT_W-1:0] baud_cnt_r, baud_cnt_s;
    logic [2:0]            bit_idx_r, bit_idx_s;
    logic [DATA_BITS-1:0]  shift_reg_r, shift_reg_s;
    logic [DATA_BITS-1:0]  data_out_r, data_out_s;
    logic                  data_valid_r, data_valid_s;
    logic                  framing_error_r, framing_error_s;
    logic                  busy_r, busy_s;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .rx_in (rx_bus.rx_in),
        .rx_s  (rx_s),
        .fall  (fall_s)
    );

    // Next-state, datapath and strobe decode; counter is cleared on every state entry
    always_comb begin
        state_s         = state_r;
        baud_cnt_s      = baud_cnt_r + {{(BAUD_CNT_W-1){1'b0}}, 1'b1};
        bit_idx_s       = bit_idx_r;
        shift_reg_s     = shift_reg_r;
        data_out_s      = data_out_r;
        data_valid_s    = 1'b0;
        framing_error_s = 1'b0;
        case (state_r)
            IDLE: begin
                baud_cnt_s = '0;
                bit_idx_s  = 3'd0;
                // Only a true edge starts a frame, so a held-low break cannot retrigger
                if (fall_s) begin
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (baud_cnt_r == BAUD_HALF) begin
                    baud_cnt_s = '0;
                    if (!rx_s) begin
                        state_s = DATA;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (baud_cnt_r == BAUD_MAX) begin
                    baud_cnt_s  = '0;
                    shift_reg_s = {rx_s, shift_reg_r[DATA_BITS-1:1]};
                    if (bit_idx_r == 3'd7) begin
                        state_s = STOP;
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    state_s = DATA;
                end
            end
            STOP: begin
                if (baud_cnt_r == BAUD_MAX) begin
                    baud_cnt_s = '0;
                    state_s    = IDLE;
                    if (rx_s) begin
                        data_out_s   = shift_reg_r;
                        data_valid_s = 1'b1;
                    end else begin
                        framing_error_s = 1'b1;
                    end
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                state_s    = IDLE;
                baud_cnt_s = '0;
                bit_idx_s  = 3'd0;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State, datapath and registered output stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= IDLE;
            baud_cnt_r      <= '0;
            bit_idx_r       <= 3'd0;
            shift_reg_r     <= 8'h00;
            data_out_r      <= 8'h00;
            data_valid_r    <= 1'b0;
            framing_error_r <= 1'b0;
            busy_r          <= 1'b0;
        end else begin
            state_r         <= state_s;
            baud_cnt_r      <= baud_cnt_s;
            bit_idx_r       <= bit_idx_s;
            shift_reg_r     <= shift_reg_s;
            data_out_r      <= data_out_s;
            data_valid_r    <= data_valid_s;
            framing_error_r <= framing_error_s;
            busy_r          <= busy_s;
        end
    end

    assign rx_bus.data_out      = data_out_r;
    assign rx_bus.data_valid    = data_valid_r;
    assign rx_bus.framing_error = framing_error_r;
    assign rx_bus.busy          = busy_r;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: bit-banged 8N1 frames compared against
// a frame-level model of which bytes should appear and which should be rejected.
module tb_uart_receiver;

    localparam int MBC      = 15;
    localparam int BIT_CLKS = MBC + 1;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    uart_receiver_if bus ();

    uart_receiver #(.max_baud_count(MBC)) dut (
        .clk    (clk),
        .reset  (reset),
        .rx_bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] got_q[$];
    int   fe_cnt      = 0;
    int   both_cnt    = 0;
    int   long_cnt    = 0;
    int   busy_hi_cnt = 0;
    logic prev_dv     = 1'b0;
    logic prev_fe     = 1'b0;
    logic [7:0] last_good = 8'h00;

    // Output monitor on the inactive edge
    always @(negedge clk) begin
        if (bus.data_valid === 1'b1) got_q.push_back(bus.data_out);
        if (bus.framing_error === 1'b1) fe_cnt++;
        if (bus.data_valid === 1'b1 && bus.framing_error === 1'b1) both_cnt++;
        if ((bus.data_valid === 1'b1 && prev_dv) || (bus.framing_error === 1'b1 && prev_fe)) long_cnt++;
        prev_dv = (bus.data_valid === 1'b1);
        prev_fe = (bus.framing_error === 1'b1);
        if (bus.busy === 1'b1) busy_hi_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input int bclks, input logic stop_bit);
        bus.rx_in = 1'b0;
        tick(bclks);
        for (int i = 0; i < 8; i++) begin
            bus.rx_in = b[i];
            tick(bclks);
        end
        bus.rx_in = stop_bit;
        tick(bclks);
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bus.rx_in = 1'b1;
        tick(3);
        checks++;
        if ({bus.data_out, bus.data_valid, bus.framing_error, bus.busy} !== 11'h000) begin
            failures++;
            $display("FAIL reset_in got=%h exp=000", {bus.data_out, bus.data_valid, bus.framing_error, bus.busy});
        end
        reset = 1'b0;
        tick(5);
        checks++;
        if ({bus.data_out, bus.data_valid, bus.framing_error, bus.busy} !== 11'h000) begin
            failures++;
            $display("FAIL reset_after got=%h exp=000", {bus.data_out, bus.data_valid, bus.framing_error, bus.busy});
        end
    endtask

    task automatic test_loopback();
        int base = got_q.size();
        int fb   = fe_cnt;
        logic [7:0] g;
        send_frame(8'hA5, BIT_CLKS, 1'b1);
        bus.rx_in = 1'b1;
        tick(20);
        last_good = 8'hA5;
        checks++;
        if (got_q.size() - base != 1) begin
            failures++;
            $display("FAIL loopback_count got=%0d exp=1", got_q.size() - base);
        end
        g = (got_q.size() > base) ? got_q[base] : 8'hxx;
        checks++;
        if (g !== 8'hA5) begin
            failures++;
            $display("FAIL loopback_byte got=%h exp=a5", g);
        end
        checks++;
        if (fe_cnt != fb || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL loopback_status got_fe=%0d busy=%b exp_fe=0 busy=0", fe_cnt - fb, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q[$];
        int base = got_q.size();
        logic [7:0] g;
        exp_q = '{8'h00, 8'hFF, 8'h01};
        foreach (exp_q[i]) send_frame(exp_q[i], BIT_CLKS, 1'b1);
        bus.rx_in = 1'b1;
        tick(20);
        last_good = exp_q[$];
        checks++;
        if (got_q.size() - base != exp_q.size()) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=%0d", got_q.size() - base, exp_q.size());
        end
        foreach (exp_q[i]) begin
            g = (got_q.size() > base + i) ? got_q[base + i] : 8'hxx;
            checks++;
            if (g !== exp_q[i]) begin
                failures++;
                $display("FAIL b2b_byte%0d got=%h exp=%h", i, g, exp_q[i]);
            end
        end
    endtask

    task automatic test_glitch();
        int base = got_q.size();
        int fb   = fe_cnt;
        int bb   = busy_hi_cnt;
        bus.rx_in = 1'b0;
        tick(4);
        bus.rx_in = 1'b1;
        tick(40);
        checks++;
        if (busy_hi_cnt == bb || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL glitch_busy got_hi_cycles=%0d busy_now=%b exp_hi>0 busy_now=0", busy_hi_cnt - bb, bus.busy);
        end
        checks++;
        if (got_q.size() != base || fe_cnt != fb) begin
            failures++;
            $display("FAIL glitch_pulses got_valid=%0d fe=%0d exp=0/0", got_q.size() - base, fe_cnt - fb);
        end
    endtask

    task automatic test_framing();
        int base = got_q.size();
        int fb   = fe_cnt;
        logic [7:0] g;
        send_frame(8'h3C, BIT_CLKS, 1'b0);
        tick(100);
        checks++;
        if (fe_cnt - fb != 1 || got_q.size() != base) begin
            failures++;
            $display("FAIL framing_pulses got_fe=%0d valid=%0d exp=1/0", fe_cnt - fb, got_q.size() - base);
        end
        checks++;
        if (bus.data_out !== last_good || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL framing_hold got=%h busy=%b exp=%h busy=0", bus.data_out, bus.busy, last_good);
        end
        bus.rx_in = 1'b1;
        tick(5);
        send_frame(8'h55, BIT_CLKS, 1'b1);
        bus.rx_in = 1'b1;
        tick(20);
        last_good = 8'h55;
        g = (got_q.size() == base + 1) ? got_q[base] : 8'hxx;
        checks++;
        if (g !== 8'h55 || fe_cnt - fb != 1) begin
            failures++;
            $display("FAIL framing_recover got=%h fe=%0d exp=55 fe=1", g, fe_cnt - fb);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b = 8'hC3;
        int base = got_q.size();
        int fb   = fe_cnt;
        logic [7:0] g;
        bus.rx_in = 1'b0;
        tick(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            bus.rx_in = b[i];
            tick(BIT_CLKS);
        end
        bus.rx_in = b[4];
        tick(5);
        // Transmit stage shares the reset, so the line returns to idle
        reset     = 1'b1;
        bus.rx_in = 1'b1;
        tick(2);
        checks++;
        if ({bus.data_out, bus.data_valid, bus.framing_error, bus.busy} !== 11'h000) begin
            failures++;
            $display("FAIL midreset_in got=%h exp=000", {bus.data_out, bus.data_valid, bus.framing_error, bus.busy});
        end
        reset = 1'b0;
        last_good = 8'h00;
        tick(200);
        checks++;
        if (got_q.size() != base || fe_cnt != fb || bus.data_out !== 8'h00 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL midreset_quiet got_valid=%0d fe=%0d data=%h busy=%b exp=0/0/00/0",
                     got_q.size() - base, fe_cnt - fb, bus.data_out, bus.busy);
        end
        send_frame(8'h7E, BIT_CLKS, 1'b1);
        bus.rx_in = 1'b1;
        tick(20);
        last_good = 8'h7E;
        g = (got_q.size() == base + 1) ? got_q[base] : 8'hxx;
        checks++;
        if (g !== 8'h7E || bus.data_out !== 8'h7E) begin
            failures++;
            $display("FAIL midreset_next got=%h data_out=%h exp=7e", g, bus.data_out);
        end
    endtask

    task automatic test_stretch();
        int base = got_q.size();
        logic [7:0] g;
        send_frame(8'h96, BIT_CLKS + 1, 1'b1);
        bus.rx_in = 1'b1;
        tick(20);
        last_good = 8'h96;
        g = (got_q.size() == base + 1) ? got_q[base] : 8'hxx;
        checks++;
        if (g !== 8'h96) begin
            failures++;
            $display("FAIL stretch_byte got=%h exp=96", g);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        int   exp_fe = 0;
        int   base   = got_q.size();
        int   fb     = fe_cnt;
        logic [7:0] b;
        logic stop_bit;
        int   gap;
        logic [7:0] g;
        for (int n = 0; n < 10; n++) begin
            b        = 8'($urandom);
            stop_bit = ($urandom_range(0, 3) != 0);
            gap      = $urandom_range(0, 12);
            if (!stop_bit && gap < 3) gap = 3;
            if (stop_bit) begin
                exp_q.push_back(b);
                last_good = b;
            end else begin
                exp_fe++;
            end
            send_frame(b, BIT_CLKS, stop_bit);
            bus.rx_in = 1'b1;
            tick(gap);
        end
        tick(20);
        checks++;
        if (got_q.size() - base != exp_q.size() || fe_cnt - fb != exp_fe) begin
            failures++;
            $display("FAIL random_counts got_valid=%0d fe=%0d exp=%0d/%0d",
                     got_q.size() - base, fe_cnt - fb, exp_q.size(), exp_fe);
        end
        foreach (exp_q[i]) begin
            g = (got_q.size() > base + i) ? got_q[base + i] : 8'hxx;
            checks++;
            if (g !== exp_q[i]) begin
                failures++;
                $display("FAIL random_byte%0d got=%h exp=%h", i, g, exp_q[i]);
            end
        end
        checks++;
        if (bus.data_out !== last_good) begin
            failures++;
            $display("FAIL random_hold got=%h exp=%h", bus.data_out, last_good);
        end
    endtask

    initial begin
        reset     = 1'b0;
        bus.rx_in = 1'b1;
        tick(1);
        test_reset();
        test_loopback();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_reset_mid_frame();
        test_stretch();
        test_random();
        checks++;
        if (both_cnt != 0 || long_cnt != 0) begin
            failures++;
            $display("FAIL strobe_shape got_both=%0d long=%0d exp=0/0", both_cnt, long_cnt);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
